cm_sort_arb: RTL

- Shares one external cm_sort pipeline between RCNT requesters.
- Round-robin arbitration picks at most one request per cycle, registers it into the sorter, and tags it with the requester index.
- Sorter results are buffered in a result FIFO and returned, with their tag, over a valid/ready response port.
- A credit counter guarantees the non-stallable sorter output never overflows the result FIFO.

---
 rtl/cm_pkg_sort.sv | 29 ++
 rtl/cm_fifo_s.sv | 45 ++++
 rtl/cm_sort_arb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cm_pkg_sort.sv
// Shared types and helpers for the cm_sort arbiter: vector type, tag width, round-robin search.
package cm_pkg_sort;

  localparam int unsigned VEC_DCNT   = 4;
  localparam int unsigned VEC_DWIDTH = 8;
  localparam int unsigned RR_MAXN    = 32;

  typedef logic [VEC_DCNT-1:0][VEC_DWIDTH-1:0] t_vec;

  function automatic int tag_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One-hot grant of the first set req bit after ptr, wrapping within n requesters.
  function automatic logic [RR_MAXN-1:0] rr_next(input logic [RR_MAXN-1:0] req,
                                                 input int unsigned ptr,
                                                 input int unsigned n);
    logic [RR_MAXN-1:0] gnt;
    int unsigned        idx;
    gnt = '0;
    for (int unsigned i = 1; i <= RR_MAXN; i++) begin
      idx = (ptr + i) % n;
      if (i <= n && gnt == '0 && req[idx[4:0]])
        gnt[idx[4:0]] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/cm_fifo_s.sv
// Synchronous FIFO with async active-low reset; push when full and pop when empty are ignored.
module cm_fifo_s #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CW-1:0]    o_count
);
  localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == CW'(DEPTH));
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;
  assign o_data  = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      o_count <= o_count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/cm_sort_arb.sv
// Round-robin front end sharing one cm_sort pipeline among RCNT requesters with credit-protected result FIFO.
// Optional statistics counters enabled by `define CM_SORT_ARB_STAT_EN.
module cm_sort_arb
  import cm_pkg_sort::*;
#(
  parameter  int unsigned RCNT   = 4,
  parameter  int unsigned DCNT   = 4,
  parameter  int unsigned DWIDTH = 8,
  parameter  int unsigned FDEPTH = 4,
  localparam int unsigned TWIDTH = tag_width(RCNT)
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [RCNT-1:0]                     i_req_vld,
  output logic [RCNT-1:0]                     o_req_rdy,
  input  logic [RCNT-1:0][DCNT-1:0][DWIDTH-1:0] i_req_data,
  output logic                                o_srt_vld,
  output logic [DCNT-1:0][DWIDTH-1:0]         o_srt_data,
  input  logic                                i_srt_vld,
  input  logic [DCNT-1:0][DWIDTH-1:0]         i_srt_data,
  output logic                                o_rsp_vld,
  input  logic                                i_rsp_rdy,
  output logic [TWIDTH-1:0]                   o_rsp_tag,
  output logic [DCNT-1:0][DWIDTH-1:0]         o_rsp_data,
  output logic                                o_err
`ifdef CM_SORT_ARB_STAT_EN
  ,
  output logic [31:0]                         o_stat_issue,
  output logic [31:0]                         o_stat_stall
`endif
);
  localparam int unsigned CW = $clog2(FDEPTH + 1);
  localparam int unsigned VW = DCNT * DWIDTH;
  localparam int unsigned RW = TWIDTH + VW;

  logic [CW-1:0]                 credit;
  logic [TWIDTH-1:0]             rr_ptr;
  logic [RR_MAXN-1:0]            gnt_full;
  logic [RCNT-1:0]               gnt;
  logic [TWIDTH-1:0]             gnt_idx;
  logic [DCNT-1:0][DWIDTH-1:0]   gnt_vec;
  logic                          can_issue, issue, rsp_pop;
  logic                          tag_empty, tag_full, res_empty, res_full;
  logic [TWIDTH-1:0]             tag_head;
  logic [RW-1:0]                 res_head;
  logic                          srt_take, srt_err;
  logic [CW-1:0]                 tag_cnt, res_cnt;
  logic                          unused_ok;

  // Credits cover FIFO occupancy plus sorts in flight; the sorter can never be stalled.
  assign can_issue = (credit < CW'(FDEPTH));
  assign gnt_full  = rr_next(RR_MAXN'(i_req_vld), 32'(rr_ptr), RCNT);
  assign gnt       = gnt_full[RCNT-1:0];
  assign o_req_rdy = can_issue ? gnt : '0;
  assign issue     = can_issue & (|gnt);

  always_comb begin
    gnt_idx = '0;
    gnt_vec = '0;
    for (int unsigned i = 0; i < RCNT; i++) begin
      if (gnt[i]) begin
        gnt_idx = TWIDTH'(i);
        gnt_vec = i_req_data[i];
      end
    end
  end

  assign srt_take   = i_srt_vld & ~tag_empty;
  assign srt_err    = i_srt_vld & tag_empty;
  assign o_rsp_vld  = ~res_empty;
  assign rsp_pop    = o_rsp_vld & i_rsp_rdy;
  assign o_rsp_tag  = res_head[RW-1 -: TWIDTH];
  assign o_rsp_data = res_head[VW-1:0];
  assign unused_ok  = ^{tag_cnt, res_cnt, tag_full, res_full};

  cm_fifo_s #(.DEPTH(FDEPTH), .WIDTH(TWIDTH)) u_tag_q (
    .i_clk, .i_rst_n,
    .i_push (issue),
    .i_pop  (srt_take),
    .i_data (gnt_idx),
    .o_data (tag_head),
    .o_empty(tag_empty),
    .o_full (tag_full),
    .o_count(tag_cnt)
  );

  cm_fifo_s #(.DEPTH(FDEPTH), .WIDTH(RW)) u_res_q (
    .i_clk, .i_rst_n,
    .i_push (srt_take),
    .i_pop  (rsp_pop),
    .i_data ({tag_head, i_srt_data}),
    .o_data (res_head),
    .o_empty(res_empty),
    .o_full (res_full),
    .o_count(res_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_srt_vld  <= 1'b0;
      o_srt_data <= '0;
      rr_ptr     <= TWIDTH'(RCNT - 1);
      credit     <= '0;
      o_err      <= 1'b0;
    end else begin
      o_srt_vld <= issue;
      if (issue) begin
        o_srt_data <= gnt_vec;
        rr_ptr     <= gnt_idx;
      end
      credit <= credit + CW'(issue) - CW'(rsp_pop);
      if (srt_err) o_err <= 1'b1;
    end
  end

`ifdef CM_SORT_ARB_STAT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_issue <= '0;
      o_stat_stall <= '0;
    end else begin
      if (issue) o_stat_issue <= o_stat_issue + 32'd1;
      if ((|i_req_vld) && credit == CW'(FDEPTH)) o_stat_stall <= o_stat_stall + 32'd1;
    end
  end
`endif

endmodule
